ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 91 +++++++++
 tb/tb_ifetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction prefetch unit with 2-entry buffer and redirect handling
module ifetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_ready,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_dout,
  input  logic        mem_en_out,
  output logic [15:0] ins,
  output logic [15:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ack,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] fifo_ins [2];
  logic [15:0] fifo_pc  [2];
  logic        head;
  logic [1:0]  count;
  logic        tail;
  logic        push;
  logic        pop;

  assign tail      = head ^ count[0];
  assign push      = (state == WAIT) && mem_en_out && !redirect;
  assign pop       = ins_ack && (count != 2'd0) && !redirect;
  assign ins       = fifo_ins[head];
  assign ins_pc    = fifo_pc[head];
  assign ins_valid = (count != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      mem_ready <= 1'b0;
      mem_addr  <= RESET_PC;
      head      <= 1'b0;
      count     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_ins[i] <= '0;
        fifo_pc[i]  <= '0;
      end
    end else begin
      mem_ready <= 1'b0;
      if (redirect) begin
        // Flush wins over pop and over a same-cycle response; an in-flight
        // request still has to be drained before the next strobe.
        head  <= 1'b0;
        count <= 2'd0;
        pc    <= redirect_pc;
        case (state)
          WAIT:    state <= mem_en_out ? IDLE : DISCARD;
          DISCARD: if (mem_en_out) state <= IDLE;
          default: state <= IDLE;
        endcase
      end else begin
        if (push) begin
          fifo_ins[tail] <= mem_dout;
          fifo_pc[tail]  <= mem_addr;
        end
        if (pop) head <= ~head;
        count <= count + 2'(push) - 2'(pop);
        case (state)
          IDLE: begin
            if (count != 2'd2) begin
              mem_ready <= 1'b1;
              mem_addr  <= pc;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (mem_en_out) begin
              pc    <= mem_addr + 16'd1;
              state <= IDLE;
            end
          end
          DISCARD: if (mem_en_out) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with a latency-configurable ROM
module tb_ifetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_dout;
  logic        mem_en_out;
  logic [15:0] ins;
  logic [15:0] ins_pc;
  logic        ins_valid;
  logic        ins_ack;
  logic        redirect;
  logic [15:0] redirect_pc;

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_dout    (mem_dout),
    .mem_en_out  (mem_en_out),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .ins_ack     (ins_ack),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        redir;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] addr;
    logic        val;
    logic [15:0] pc;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;

  // Reference: queue of buffered fetch addresses and the address the next fetch must use
  logic [15:0] q[$];
  logic [15:0] next_fetch;
  logic        rom_pend   = 1'b0;
  logic        rom_stale  = 1'b0;
  logic [15:0] rom_addr   = '0;
  int          rom_delay  = 0;
  logic        resp_stale = 1'b0;
  logic [15:0] resp_addr  = '0;
  logic        rand_lat   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ack, input logic redir, input logic [15:0] rpc,
                     input logic rdy, input logic [15:0] addr, input logic val, input logic [15:0] pc);
    vec_t v;
    v.ack = ack; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.addr = addr; v.val = val; v.pc = pc;
    tbl.push_back(v);
  endtask

  task automatic step();
    logic        r, a, en, en_st, rs;
    logic [15:0] rp, ea;
    int          pre;
    r = redirect; rp = redirect_pc; a = ins_ack; en = mem_en_out;
    en_st = resp_stale; ea = resp_addr; pre = q.size(); rs = rst;
    @(posedge clk);
    @(negedge clk);
    if (rs && rst) begin
      if (r) begin
        q.delete();
        next_fetch = rp;
        if (rom_pend) rom_stale = 1'b1;
      end else begin
        if (a && pre > 0) begin
          void'(q.pop_front());
          pops++;
        end
        if (en && !en_st) begin
          q.push_back(ea);
          next_fetch = ea + 16'd1;
        end
      end
    end
    check("ins_valid", ins_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("ins_pc", ins_pc, q[0]);
      check("ins", ins, q[0] ^ 16'hA5A5);
    end
    if (mem_ready) begin
      check("strobe_on_redirect", r, 0);
      check("strobe_addr", mem_addr, next_fetch);
      check("one_outstanding", rom_pend, 0);
      check("strobe_room", pre < 2, 1);
    end
    if (rom_pend) check("addr_hold", mem_addr, rom_addr);
    mem_en_out = 1'b0;
    resp_stale = 1'b0;
    if (rom_pend) begin
      rom_delay--;
      if (rom_delay == 0) begin
        mem_en_out = 1'b1;
        mem_dout   = rom_addr ^ 16'hA5A5;
        resp_addr  = rom_addr;
        resp_stale = rom_stale;
        rom_pend   = 1'b0;
      end
    end
    if (mem_ready) begin
      rom_pend  = 1'b1;
      rom_stale = 1'b0;
      rom_addr  = mem_addr;
      rom_delay = rand_lat ? int'($urandom_range(1, 3)) : 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic found;
    rst = 1'b1; ins_ack = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_en_out = 1'b0; mem_dout = '0;
    next_fetch = RST_PC;
    #1 rst = 1'b0;
    step();
    step();
    check("rst mem_ready", mem_ready, 0);
    check("rst mem_addr", mem_addr, RST_PC);
    check("rst ins_valid", ins_valid, 0);
    check("rst ins", ins, 0);
    check("rst ins_pc", ins_pc, 0);

    // ack, redir, rpc, exp mem_ready, exp mem_addr, exp ins_valid, exp ins_pc (1-cycle ROM)
    add(0,0,16'h0000, 1,16'h0000, 0,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0000);
    add(0,0,16'h0000, 1,16'h0001, 1,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0000);
    add(1,0,16'h0000, 0,16'h0000, 1,16'h0001);
    add(0,0,16'h0000, 1,16'h0002, 1,16'h0001);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0001);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0001);
    add(1,0,16'h0000, 0,16'h0000, 1,16'h0002);
    add(0,0,16'h0000, 1,16'h0003, 1,16'h0002);
    add(0,1,16'h0040, 0,16'h0000, 0,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0,0,16'h0000, 1,16'h0040, 0,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0040);
    add(1,1,16'hFFFF, 0,16'h0000, 0,16'h0000);
    add(1,0,16'h0000, 1,16'hFFFF, 0,16'h0000);
    add(1,0,16'h0000, 0,16'h0000, 0,16'h0000);
    add(1,0,16'h0000, 0,16'h0000, 1,16'hFFFF);
    add(1,0,16'h0000, 1,16'h0000, 0,16'h0000);
    add(1,0,16'h0000, 0,16'h0000, 0,16'h0000);
    add(1,0,16'h0000, 0,16'h0000, 1,16'h0000);
    add(1,0,16'h0000, 1,16'h0001, 0,16'h0000);
    add(1,0,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0001);
    add(0,0,16'h0000, 1,16'h0002, 1,16'h0001);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h0001);
    add(1,1,16'h1234, 0,16'h0000, 0,16'h0000);
    add(0,0,16'h0000, 1,16'h1234, 0,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 0,16'h0000);
    add(0,0,16'h0000, 0,16'h0000, 1,16'h1234);

    rst = 1'b1;
    for (int k = 0; k < tbl.size(); k++) begin
      ins_ack = tbl[k].ack; redirect = tbl[k].redir; redirect_pc = tbl[k].rpc;
      step();
      check($sformatf("vec%0d mem_ready", k), mem_ready, tbl[k].rdy);
      if (tbl[k].rdy) check($sformatf("vec%0d mem_addr", k), mem_addr, tbl[k].addr);
      check($sformatf("vec%0d ins_valid", k), ins_valid, tbl[k].val);
      if (tbl[k].val) check($sformatf("vec%0d ins_pc", k), ins_pc, tbl[k].pc);
    end

    // Reset in the middle of an outstanding fetch, response shows up at release
    ins_ack = 1'b0; redirect = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      found = mem_ready;
    end
    check("reach_wait", found, 1);
    rst = 1'b0;
    #1;
    check("midwait_rst mem_ready", mem_ready, 0);
    check("midwait_rst mem_addr", mem_addr, RST_PC);
    check("midwait_rst ins_valid", ins_valid, 0);
    q.delete();
    next_fetch = RST_PC;
    rom_pend = 1'b0; mem_en_out = 1'b0; resp_stale = 1'b0;
    step();
    step();
    rst = 1'b1;
    mem_en_out = 1'b1; mem_dout = 16'hDEAD; resp_addr = 16'h0BAD; resp_stale = 1'b1;
    step();
    check("late_resp ins_valid", ins_valid, 0);
    check("late_resp mem_ready", mem_ready, 1);
    check("late_resp mem_addr", mem_addr, RST_PC);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      found = ins_valid;
    end
    check("refetch ins_valid", found, 1);
    check("refetch ins_pc", ins_pc, RST_PC);

    // Randomised traffic against the reference queue
    rand_lat = 1'b1;
    pops = 0;
    for (int k = 0; k < 2000; k++) begin
      ins_ack  = ($urandom_range(0, 9) < 6);
      redirect = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFE + 16'($urandom_range(0, 1));
      else redirect_pc = 16'($urandom);
      step();
    end
    check("random_deliveries", pops > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
